// File: rtl/avalon_read_arbiter_if.sv
// Avalon-MM read-only bus bundle: read, address, byteenable requests and
// waitrequest, readdata, readdatavalid responses. Master drives requests.
interface avalon_read_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);
    logic                    read;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    waitrequest;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;

    modport master (
        output read, address, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, address, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avalon_read_arbiter.sv
// Two-master arbiter onto one pipelined Avalon-MM read slave. m0 (video
// scan-out) has fixed priority; a starve counter guarantees m1 (blitter/CPU)
// a slot after STARVE_LIMIT consecutive m0 wins. A tag FIFO of owners routes
// each readdatavalid back in accept order.
// Ports: clk, reset (sync, active-high); m0/m1 slave-side buses; s master-side
// bus to memory; err_unexpected sticky flag for responses with nothing pending.
module avalon_read_arbiter #(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 16,
    parameter int MAX_PENDING_READS = 4,
    parameter int STARVE_LIMIT      = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    avalon_read_arbiter_if.slave   m0,
    avalon_read_arbiter_if.slave   m1,
    avalon_read_arbiter_if.master  s,
    output logic                   err_unexpected
);
    localparam int CW = $clog2(MAX_PENDING_READS + 1);
    localparam int PW = (MAX_PENDING_READS > 1) ? $clog2(MAX_PENDING_READS) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_PENDING_READS);
    localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_PENDING_READS - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          tag_q [MAX_PENDING_READS];
    logic          tag_d [MAX_PENDING_READS];
    logic          lock_q, lock_d;
    logic          lock_id_q, lock_id_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          err_q, err_d;

    logic full;
    logic lock_live;
    logic gnt_vld;
    logic gnt_id;
    logic accept;
    logic pop;
    logic head_id;

    // Grant and request mux. A lock whose owner dropped read is ignored so
    // arbitration falls back to the normal priority rules.
    always_comb begin
        full      = (count_q == CNT_MAX);
        lock_live = lock_q & (lock_id_q ? m1.read : m0.read);
        gnt_vld   = 1'b0;
        gnt_id    = 1'b0;
        if (!reset && !full) begin
            if (lock_live) begin
                gnt_vld = 1'b1;
                gnt_id  = lock_id_q;
            end else if (m0.read && m1.read) begin
                gnt_vld = 1'b1;
                gnt_id  = (starve_q == STARVE_MAX);
            end else if (m0.read || m1.read) begin
                gnt_vld = 1'b1;
                gnt_id  = m1.read;
            end
        end

        s.read       = gnt_vld;
        s.address    = '0;
        s.byteenable = '0;
        if (gnt_vld) begin
            s.address    = gnt_id ? m1.address : m0.address;
            s.byteenable = gnt_id ? m1.byteenable : m0.byteenable;
        end

        m0.waitrequest = (gnt_vld && !gnt_id) ? s.waitrequest : 1'b1;
        m1.waitrequest = (gnt_vld &&  gnt_id) ? s.waitrequest : 1'b1;
        accept         = gnt_vld & ~s.waitrequest;

        // Response path: pop the owner at the FIFO head, no added latency.
        pop               = ~reset & s.readdatavalid & (count_q != '0);
        head_id           = tag_q[rd_ptr_q];
        m0.readdatavalid  = pop & ~head_id;
        m1.readdatavalid  = pop &  head_id;
        m0.readdata       = s.readdata;
        m1.readdata       = s.readdata;
        err_unexpected    = err_q;
    end

    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (accept) begin
            tag_d[wr_ptr_q] = gnt_id;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        unique case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (accept && gnt_id) begin
            starve_d = '0;
        end else if (accept && m1.read && starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
        // A stalled request holds its grant; any accept or drop releases it.
        lock_d    = gnt_vld & s.waitrequest;
        lock_id_d = gnt_id;
        err_d     = err_q | (~reset & s.readdatavalid & (count_q == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tag_q     <= '{default: 1'b0};
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            starve_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tag_q     <= tag_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            starve_q  <= starve_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_avalon_read_arbiter.sv
// Self-checking bench for avalon_read_arbiter: vector table, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_avalon_read_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 16;
    localparam int MAXP = 4;
    localparam int SL   = 3;

    logic clk;
    logic reset;
    logic err;

    avalon_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    avalon_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    avalon_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

    avalon_read_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MAX_PENDING_READS(MAXP), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .m0(m0_if), .m1(m1_if), .s(s_if),
        .err_unexpected(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Counter-initialised 16-bit memory: word n holds n.
    function automatic logic [15:0] mem(input logic [31:0] a);
        return a[16:1];
    endfunction

    typedef struct { int due; logic [15:0] data; } resp_t;
    typedef struct { int owner; logic [15:0] data; } rlog_t;

    // Slave model controls
    resp_t rq[$];
    int    lat;
    bit    s_stall;
    bit    withhold;
    bit    stray;
    int    cyc = 0;

    // Reference model state
    int owners[$];
    bit mlk;
    int mlk_id;
    int mstarve;
    bit merr;

    // Observations of the DUT in the last cycle
    bit          a_acc, a_acc0, a_acc1, a_v0, a_v1, a_sread, a_w0, a_w1, a_err;
    logic [31:0] a_addr;
    int          acc_log[$];
    int          acc_cyc[$];
    int          pop_cyc[$];
    rlog_t       rsp_log[$];

    task automatic cycle();
        bit          rdv, from_q, r0, r1, full, mpop, macc;
        int          g;
        logic [15:0] d;
        logic [31:0] ea;
        logic [1:0]  eb;
        logic [41:0] act, exp;
        s_if.waitrequest = s_stall;
        rdv = 1'b0;
        from_q = 1'b0;
        d = 16'($urandom);
        if (!withhold && rq.size() > 0 && rq[0].due <= cyc) begin
            rdv = 1'b1;
            from_q = 1'b1;
            d = rq[0].data;
        end else if (stray) begin
            rdv = 1'b1;
        end
        s_if.readdatavalid = rdv;
        s_if.readdata = d;
        #1;
        r0 = m0_if.read;
        r1 = m1_if.read;
        full = owners.size() >= MAXP;
        g = -1;
        if (!full) begin
            if (mlk && ((mlk_id == 0) ? r0 : r1)) g = mlk_id;
            else if (r0 && r1) g = (mstarve == SL) ? 1 : 0;
            else if (r0) g = 0;
            else if (r1) g = 1;
        end
        ea = (g == 0) ? m0_if.address : (g == 1) ? m1_if.address : 32'h0;
        eb = (g == 0) ? m0_if.byteenable : (g == 1) ? m1_if.byteenable : 2'b00;
        mpop = rdv && owners.size() > 0;
        exp = {g >= 0, ea, eb,
               (g == 0) ? s_stall : 1'b1, (g == 1) ? s_stall : 1'b1,
               mpop && owners[0] == 0, mpop && owners[0] == 1,
               1'b1, 1'b1, merr};
        act = {s_if.read, s_if.address, s_if.byteenable,
               m0_if.waitrequest, m1_if.waitrequest,
               m0_if.readdatavalid, m1_if.readdatavalid,
               m0_if.readdata == d, m1_if.readdata == d, err};
        chk($sformatf("model_cyc%0d", cyc), 64'(act), 64'(exp));

        a_sread = s_if.read;
        a_addr  = s_if.address;
        a_w0    = m0_if.waitrequest;
        a_w1    = m1_if.waitrequest;
        a_v0    = m0_if.readdatavalid;
        a_v1    = m1_if.readdatavalid;
        a_err   = err;
        a_acc   = s_if.read && !s_stall;
        a_acc0  = a_acc && !m0_if.waitrequest;
        a_acc1  = a_acc && !m1_if.waitrequest;
        if (a_acc) begin
            acc_log.push_back(a_acc1 ? 1 : 0);
            acc_cyc.push_back(cyc);
            rq.push_back('{cyc + lat, mem(s_if.address)});
        end
        if (a_v0) rsp_log.push_back('{0, m0_if.readdata});
        if (a_v1) rsp_log.push_back('{1, m1_if.readdata});
        if (a_v0 || a_v1) pop_cyc.push_back(cyc);
        if (from_q) void'(rq.pop_front());

        macc = g >= 0 && !s_stall;
        if (rdv && owners.size() == 0) merr = 1'b1;
        if (mpop) void'(owners.pop_front());
        if (macc) begin
            owners.push_back(g);
            if (g == 1) mstarve = 0;
            else if (r1 && mstarve < SL) mstarve++;
        end
        if (macc) mlk = 1'b0;
        else if (g >= 0) begin
            mlk = 1'b1;
            mlk_id = g;
        end else if (mlk) mlk = 1'b0;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_if.read = 1'b1;
        m1_if.read = 1'b1;
        s_if.waitrequest = 1'b0;
        s_if.readdatavalid = 1'b1;
        #1;
        chk("reset_forced_outputs",
            64'({s_if.read, m0_if.waitrequest, m1_if.waitrequest,
                 m0_if.readdatavalid, m1_if.readdatavalid}),
            64'(5'b01100));
        @(negedge clk);
        @(negedge clk);
        m0_if.read = 1'b0;
        m1_if.read = 1'b0;
        s_if.readdatavalid = 1'b0;
        reset = 1'b0;
        rq.delete();
        owners.delete();
        acc_log.delete();
        acc_cyc.delete();
        pop_cyc.delete();
        rsp_log.delete();
        mlk = 1'b0;
        mlk_id = 0;
        mstarve = 0;
        merr = 1'b0;
        lat = 1;
        s_stall = 1'b0;
        withhold = 1'b0;
        stray = 1'b0;
    endtask

    typedef struct packed {
        bit m0, m1, sw, rdv;
        bit sr;
        bit [1:0] sel;
        bit w0, w1, v0, v1, er;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle, vcnt, vat, v1cnt;
        logic [15:0] vdata;
        logic [31:0] t4_addr [5];
        bit t4_acc [5];
        int exp2 [8];
        tbl = '{
            '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,1'b0},
            '{1'b1,1'b0,1'b0,1'b0, 1'b1,2'd1, 1'b0,1'b1,1'b0,1'b0,1'b0},
            '{1'b1,1'b1,1'b0,1'b1, 1'b1,2'd1, 1'b0,1'b1,1'b1,1'b0,1'b0},
            '{1'b1,1'b1,1'b1,1'b0, 1'b1,2'd1, 1'b1,1'b1,1'b0,1'b0,1'b0},
            '{1'b1,1'b1,1'b0,1'b1, 1'b1,2'd1, 1'b0,1'b1,1'b1,1'b0,1'b0},
            '{1'b1,1'b1,1'b0,1'b0, 1'b1,2'd1, 1'b0,1'b1,1'b0,1'b0,1'b0},
            '{1'b1,1'b1,1'b1,1'b0, 1'b1,2'd2, 1'b1,1'b1,1'b0,1'b0,1'b0},
            '{1'b1,1'b1,1'b0,1'b1, 1'b1,2'd2, 1'b1,1'b0,1'b1,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,1'b1, 1'b0,2'd0, 1'b1,1'b1,1'b1,1'b0,1'b0},
            '{1'b0,1'b1,1'b1,1'b0, 1'b1,2'd2, 1'b1,1'b1,1'b0,1'b0,1'b0},
            '{1'b1,1'b0,1'b0,1'b1, 1'b1,2'd1, 1'b0,1'b1,1'b0,1'b1,1'b0},
            '{1'b0,1'b0,1'b0,1'b1, 1'b0,2'd0, 1'b1,1'b1,1'b1,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,1'b1, 1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,1'b1}
        };
        m0_if.address = 32'h0;
        m1_if.address = 32'h0;
        m0_if.byteenable = 2'b11;
        m1_if.byteenable = 2'b11;
        s_if.readdata = 16'h0;

        // Vector table: grant, lock, starve, routing, stray response.
        do_reset();
        m0_if.address = 32'h100;
        m1_if.address = 32'h200;
        for (int i = 0; i < 14; i++) begin
            logic [1:0] sel;
            m0_if.read = tbl[i].m0;
            m1_if.read = tbl[i].m1;
            s_if.waitrequest = tbl[i].sw;
            s_if.readdatavalid = tbl[i].rdv;
            s_if.readdata = 16'hA500 + 16'(i);
            #1;
            sel = (s_if.address == 32'h100) ? 2'd1 :
                  (s_if.address == 32'h200) ? 2'd2 :
                  (s_if.address == 32'h0)   ? 2'd0 : 2'd3;
            chk($sformatf("tbl_row%0d", i),
                64'({s_if.read, sel, m0_if.waitrequest, m1_if.waitrequest,
                     m0_if.readdatavalid, m1_if.readdatavalid, err,
                     m0_if.readdata == s_if.readdata,
                     m1_if.readdata == s_if.readdata}),
                64'({tbl[i].sr, tbl[i].sel, tbl[i].w0, tbl[i].w1,
                     tbl[i].v0, tbl[i].v1, tbl[i].er, 1'b1, 1'b1}));
            @(negedge clk);
        end

        // Single m0 read, latency 6.
        do_reset();
        lat = 6;
        m0_if.read = 1'b1;
        m0_if.address = 32'h10;
        cycle();
        chk("t1_first_cycle_accept", 64'(a_acc0), 64'(1));
        m0_if.read = 1'b0;
        vcnt = 0; v1cnt = 0; vat = -1; vdata = 16'hFFFF;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (a_v0) begin vcnt++; vat = i; vdata = rsp_log[$].data; end
            if (a_v1) v1cnt++;
        end
        chk("t1_valid_count", 64'(vcnt), 64'(1));
        chk("t1_valid_latency", 64'(vat), 64'(6));
        chk("t1_data", 64'(vdata), 64'(16'h0008));
        chk("t1_m1_quiet", 64'(v1cnt), 64'(0));

        // Both masters continuously; starve guard gives m1 every 4th slot.
        do_reset();
        lat = 2;
        m0_if.read = 1'b1; m0_if.address = 32'h1000;
        m1_if.read = 1'b1; m1_if.address = 32'h2000;
        for (int i = 0; i < 16; i++) cycle();
        m0_if.read = 1'b0; m1_if.read = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        exp2 = '{0, 0, 0, 1, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_order%0d", i),
                64'((acc_log.size() > i) ? acc_log[i] : -1), 64'(exp2[i]));

        // Pending limit with responses withheld.
        do_reset();
        withhold = 1'b1;
        m0_if.read = 1'b1; m0_if.address = 32'h40;
        for (int i = 0; i < 8; i++) cycle();
        chk("t3_accepts", 64'(acc_log.size()), 64'(4));
        chk("t3_blocked", 64'({a_sread, a_w0, a_w1}), 64'(3'b011));
        withhold = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("t3_resume",
            64'((acc_cyc.size() > 4 && pop_cyc.size() > 0) ?
                acc_cyc[4] - pop_cyc[0] : -1), 64'(1));
        m0_if.read = 1'b0;
        for (int i = 0; i < 8; i++) cycle();

        // m1 stalled three cycles, m0 arrives mid-stall.
        do_reset();
        m1_if.read = 1'b1; m1_if.address = 32'h200;
        m0_if.address = 32'h100;
        s_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) m0_if.read = 1'b1;
            if (i == 3) s_stall = 1'b0;
            cycle();
            t4_addr[i] = a_addr;
            t4_acc[i] = a_acc;
            if (a_acc1) m1_if.read = 1'b0;
            if (a_acc0) m0_if.read = 1'b0;
        end
        chk("t4_addr_hold", 64'({t4_addr[0], t4_addr[2]}), 64'({32'h200, 32'h200}));
        chk("t4_m1_first", 64'({t4_addr[3], t4_acc[2], t4_acc[3]}), 64'({32'h200, 1'b0, 1'b1}));
        chk("t4_m0_next", 64'({t4_addr[4], t4_acc[4]}), 64'({32'h100, 1'b1}));
        for (int i = 0; i < 4; i++) cycle();

        // In-order routing of interleaved owners.
        do_reset();
        lat = 3;
        m0_if.read = 1'b1; m0_if.address = 32'h00; cycle();
        m0_if.read = 1'b0;
        m1_if.read = 1'b1; m1_if.address = 32'h20; cycle();
        m1_if.read = 1'b0;
        m0_if.read = 1'b1; m0_if.address = 32'h40; cycle();
        m0_if.read = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("t5_resp_count", 64'(rsp_log.size()), 64'(3));
        if (rsp_log.size() == 3) begin
            chk("t5_resp0", 64'({rsp_log[0].owner[0], rsp_log[0].data}), 64'({1'b0, 16'h0000}));
            chk("t5_resp1", 64'({rsp_log[1].owner[0], rsp_log[1].data}), 64'({1'b1, 16'h0010}));
            chk("t5_resp2", 64'({rsp_log[2].owner[0], rsp_log[2].data}), 64'({1'b0, 16'h0020}));
        end

        // Stray response sets the sticky error.
        do_reset();
        stray = 1'b1;
        cycle();
        stray = 1'b0;
        chk("t6_no_valid", 64'({a_v0, a_v1, a_err}), 64'(3'b000));
        cycle();
        chk("t6_err_next", 64'(a_err), 64'(1));
        for (int i = 0; i < 3; i++) cycle();
        chk("t6_err_sticky", 64'(a_err), 64'(1));
        do_reset();
        cycle();
        chk("t6_err_cleared", 64'(a_err), 64'(0));

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s_stall  = ($urandom_range(0, 9) < 3);
            withhold = ($urandom_range(0, 9) < 2);
            lat      = $urandom_range(1, 5);
            if (!m0_if.read && $urandom_range(0, 1) == 1) begin
                m0_if.read = 1'b1;
                m0_if.address = {$urandom_range(0, 255), 1'b0};
                m0_if.byteenable = 2'($urandom_range(1, 3));
            end else if (m0_if.read && $urandom_range(0, 19) == 0) begin
                m0_if.read = 1'b0;
            end
            if (!m1_if.read && $urandom_range(0, 1) == 1) begin
                m1_if.read = 1'b1;
                m1_if.address = {$urandom_range(0, 255), 1'b0};
                m1_if.byteenable = 2'($urandom_range(1, 3));
            end else if (m1_if.read && $urandom_range(0, 19) == 0) begin
                m1_if.read = 1'b0;
            end
            cycle();
            if (a_acc0) m0_if.read = ($urandom_range(0, 9) < 7);
            if (a_acc1) m1_if.read = ($urandom_range(0, 9) < 7);
            if (a_acc0) m0_if.address = {$urandom_range(0, 255), 1'b0};
            if (a_acc1) m1_if.address = {$urandom_range(0, 255), 1'b0};
        end
        m0_if.read = 1'b0;
        m1_if.read = 1'b0;
        s_stall = 1'b0;
        withhold = 1'b0;
        idle = 0;
        while (rq.size() > 0 && idle < 50) begin
            cycle();
            idle++;
        end
        chk("rand_drained", 64'(rq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
